instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 tb/tb_instruction_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE sequencer with
// jump/branch next-PC selection and a single-entry instr latch.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_Req_Out,
  output logic [31:0] imem_Addr_Out,
  input  logic        imem_Ack_In,
  input  logic [31:0] imem_Data_In,
  input  logic        stall_In,
  input  logic        branch_Taken_In,
  input  logic [31:0] sign_Extended_In,
  input  logic        jump_In,
  input  logic [25:0] jump_Target_In,
  output logic [31:0] instr_Out,
  output logic        instr_Valid_Out,
  output logic [15:0] imm_Field_Out,
  output logic [31:0] pc_Out,
  output logic [31:0] pc_Plus4_Out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] next_pc;
  logic        capture;
  logic        advance;

  assign capture = (state_q == FETCH) && imem_Ack_In;
  assign advance = (state_q == ISSUE) && !stall_In;

  // Request/valid decode straight from state so reset drops them at once
  assign imem_Req_Out    = (state_q == FETCH);
  assign imem_Addr_Out   = pc_q;
  assign instr_Valid_Out = (state_q == ISSUE);
  assign instr_Out       = instr_q;
  assign imm_Field_Out   = instr_q[15:0];
  assign pc_Out          = pc_out_q;
  assign pc_Plus4_Out    = pc_out_q + 32'd4;

  // Next-PC select: jump beats branch beats fall-through
  always_comb begin
    next_pc = pc_Plus4_Out;
    if (jump_In) begin
      next_pc = {pc_Plus4_Out[31:28], jump_Target_In, 2'b00};
    end else if (branch_Taken_In) begin
      next_pc = pc_Plus4_Out + {sign_Extended_In[29:0], 2'b00};
    end
  end

  // Sequencer next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_Ack_In) state_d = ISSUE;
      ISSUE:   if (!stall_In) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch PC advances only when the presented instr is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (advance) begin
      pc_q <= next_pc;
    end
  end

  // Latch instruction and its address on the ack cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q  <= 32'd0;
      pc_out_q <= 32'd0;
    end else if (capture) begin
      instr_q  <= imem_Data_In;
      pc_out_q <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus
// randomized fetch/issue traffic against a PC-sequence model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_Req_Out;
  logic [31:0] imem_Addr_Out;
  logic        imem_Ack_In = 1'b0;
  logic [31:0] imem_Data_In = 32'd0;
  logic        stall_In = 1'b0;
  logic        branch_Taken_In = 1'b0;
  logic [31:0] sign_Extended_In = 32'd0;
  logic        jump_In = 1'b0;
  logic [25:0] jump_Target_In = 26'd0;
  logic [31:0] instr_Out;
  logic        instr_Valid_Out;
  logic [15:0] imm_Field_Out;
  logic [31:0] pc_Out;
  logic [31:0] pc_Plus4_Out;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_pcout;
  logic [31:0] exp_instr;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_Req_Out     (imem_Req_Out),
    .imem_Addr_Out    (imem_Addr_Out),
    .imem_Ack_In      (imem_Ack_In),
    .imem_Data_In     (imem_Data_In),
    .stall_In         (stall_In),
    .branch_Taken_In  (branch_Taken_In),
    .sign_Extended_In (sign_Extended_In),
    .jump_In          (jump_In),
    .jump_Target_In   (jump_Target_In),
    .instr_Out        (instr_Out),
    .instr_Valid_Out  (instr_Valid_Out),
    .imm_Field_Out    (imm_Field_Out),
    .pc_Out           (pc_Out),
    .pc_Plus4_Out     (pc_Plus4_Out)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_redirect;
    stall_In         = 1'($urandom);
    branch_Taken_In  = 1'($urandom);
    jump_In          = 1'($urandom);
    sign_Extended_In = $urandom;
    jump_Target_In   = 26'($urandom);
  endtask

  // One fetch with `delay` wait states, then the ack returning `data`
  task automatic do_fetch(input int delay, input logic [31:0] data);
    tests++;
    if (imem_Req_Out !== 1'b1 || imem_Addr_Out !== exp_pc) begin
      fails++;
      $display("FAIL fetch_req: req=%b addr=%h want req=1 addr=%h",
               imem_Req_Out, imem_Addr_Out, exp_pc);
    end
    for (int i = 0; i < delay; i++) begin
      imem_Ack_In  = 1'b0;
      imem_Data_In = $urandom;
      scramble_redirect();
      step();
      tests++;
      if (imem_Req_Out !== 1'b1 || imem_Addr_Out !== exp_pc ||
          instr_Valid_Out !== 1'b0 || instr_Out !== exp_instr ||
          pc_Out !== exp_pcout) begin
        fails++;
        $display("FAIL fetch_wait: req=%b addr=%h v=%b ins=%h pc=%h want 1 %h 0 %h %h",
                 imem_Req_Out, imem_Addr_Out, instr_Valid_Out, instr_Out,
                 pc_Out, exp_pc, exp_instr, exp_pcout);
      end
    end
    imem_Ack_In  = 1'b1;
    imem_Data_In = data;
    scramble_redirect();
    step();
    imem_Ack_In = 1'b0;
    exp_instr = data;
    exp_pcout = exp_pc;
    tests++;
    if (instr_Valid_Out !== 1'b1 || instr_Out !== exp_instr ||
        pc_Out !== exp_pcout || imm_Field_Out !== exp_instr[15:0] ||
        pc_Plus4_Out !== exp_pcout + 32'd4 || imem_Req_Out !== 1'b0) begin
      fails++;
      $display("FAIL fetch_issue: v=%b ins=%h pc=%h imm=%h p4=%h req=%b want 1 %h %h",
               instr_Valid_Out, instr_Out, pc_Out, imm_Field_Out,
               pc_Plus4_Out, imem_Req_Out, exp_instr, exp_pcout);
    end
  endtask

  // Hold in ISSUE for `stalls` cycles, then release with a redirect
  task automatic do_issue(input int stalls, input logic br,
                          input logic [31:0] off, input logic jmp,
                          input logic [25:0] tgt);
    logic [31:0] p4;
    for (int i = 0; i < stalls; i++) begin
      scramble_redirect();
      stall_In     = 1'b1;
      imem_Ack_In  = 1'($urandom);
      imem_Data_In = $urandom;
      step();
      tests++;
      if (instr_Valid_Out !== 1'b1 || imem_Req_Out !== 1'b0 ||
          instr_Out !== exp_instr || pc_Out !== exp_pcout) begin
        fails++;
        $display("FAIL issue_stall: v=%b req=%b ins=%h pc=%h want 1 0 %h %h",
                 instr_Valid_Out, imem_Req_Out, instr_Out, pc_Out,
                 exp_instr, exp_pcout);
      end
    end
    stall_In         = 1'b0;
    branch_Taken_In  = br;
    sign_Extended_In = off;
    jump_In          = jmp;
    jump_Target_In   = tgt;
    imem_Ack_In      = 1'($urandom);
    imem_Data_In     = $urandom;
    step();
    imem_Ack_In     = 1'b0;
    branch_Taken_In = 1'b0;
    jump_In         = 1'b0;
    p4 = exp_pcout + 32'd4;
    if (jmp) exp_pc = {p4[31:28], tgt, 2'b00};
    else if (br) exp_pc = p4 + off * 32'd4;
    else exp_pc = p4;
    tests++;
    if (imem_Req_Out !== 1'b1 || imem_Addr_Out !== exp_pc ||
        instr_Valid_Out !== 1'b0) begin
      fails++;
      $display("FAIL issue_next: req=%b addr=%h v=%b want 1 %h 0",
               imem_Req_Out, imem_Addr_Out, instr_Valid_Out, exp_pc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) step();
    exp_pc = 32'h0; exp_pcout = 32'h0; exp_instr = 32'h0;
    tests++;
    if (imem_Req_Out !== 1'b0 || imem_Addr_Out !== 32'h0 ||
        instr_Out !== 32'h0 || instr_Valid_Out !== 1'b0 ||
        pc_Out !== 32'h0 || pc_Plus4_Out !== 32'h4 ||
        imm_Field_Out !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: req=%b addr=%h ins=%h v=%b pc=%h p4=%h imm=%h",
               imem_Req_Out, imem_Addr_Out, instr_Out, instr_Valid_Out,
               pc_Out, pc_Plus4_Out, imm_Field_Out);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (imem_Req_Out !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: req=%b want 0", imem_Req_Out);
    end
    step();
    tests++;
    if (imem_Req_Out !== 1'b1 || imem_Addr_Out !== 32'h0) begin
      fails++;
      $display("FAIL first_req: req=%b addr=%h want 1 0",
               imem_Req_Out, imem_Addr_Out);
    end
  endtask

  task automatic test_first_fetch;
    do_fetch(0, 32'h2008_0005);
    tests++;
    if (instr_Out !== 32'h2008_0005 || imm_Field_Out !== 16'h0005 ||
        pc_Out !== 32'h0) begin
      fails++;
      $display("FAIL first_instr: ins=%h imm=%h pc=%h want 20080005 0005 0",
               instr_Out, imm_Field_Out, pc_Out);
    end
    do_issue(0, 1'b0, 32'h0, 1'b0, 26'h0);
    tests++;
    if (imem_Addr_Out !== 32'h4) begin
      fails++;
      $display("FAIL second_addr: addr=%h want 4", imem_Addr_Out);
    end
  endtask

  task automatic test_wait_states;
    do_fetch(0, $urandom);
    do_issue(0, 1'b0, 32'h0, 1'b1, 26'h4);
    tests++;
    if (imem_Addr_Out !== 32'h10) begin
      fails++;
      $display("FAIL jump_addr: addr=%h want 10", imem_Addr_Out);
    end
    do_fetch(3, $urandom);
    do_issue(0, 1'b0, 32'h0, 1'b1, 26'h10);
  endtask

  task automatic test_redirect;
    do_fetch(0, $urandom);
    tests++;
    if (pc_Out !== 32'h40) begin
      fails++;
      $display("FAIL redir_pc: pc=%h want 40", pc_Out);
    end
    do_issue(0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
    tests++;
    if (imem_Addr_Out !== 32'h3C) begin
      fails++;
      $display("FAIL branch_back: addr=%h want 3c", imem_Addr_Out);
    end
    do_fetch(0, $urandom);
    do_issue(0, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h0000100);
    tests++;
    if (imem_Addr_Out !== 32'h400) begin
      fails++;
      $display("FAIL jump_wins: addr=%h want 400", imem_Addr_Out);
    end
  endtask

  task automatic test_stall;
    do_fetch(0, $urandom);
    do_issue(5, 1'b1, 32'h1, 1'b0, 26'h0);
    tests++;
    if (imem_Addr_Out !== 32'h408) begin
      fails++;
      $display("FAIL stall_redir: addr=%h want 408", imem_Addr_Out);
    end
  endtask

  task automatic test_wrap;
    logic signed [31:0] d;
    do_fetch(0, $urandom);
    d = 32'hFFFF_FFFC - (exp_pcout + 32'd4);
    do_issue(0, 1'b1, d >>> 2, 1'b0, 26'h0);
    tests++;
    if (imem_Addr_Out !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_reach: addr=%h want fffffffc", imem_Addr_Out);
    end
    do_fetch(1, $urandom);
    tests++;
    if (pc_Plus4_Out !== 32'h0) begin
      fails++;
      $display("FAIL wrap_p4: p4=%h want 0", pc_Plus4_Out);
    end
    do_issue(0, 1'b0, 32'h0, 1'b0, 26'h0);
    tests++;
    if (imem_Addr_Out !== 32'h0) begin
      fails++;
      $display("FAIL wrap_next: addr=%h want 0", imem_Addr_Out);
    end
  endtask

  task automatic test_reset_mid_fetch;
    do_fetch(0, $urandom);
    do_issue(0, 1'b0, 32'h0, 1'b1, 26'h123);
    imem_Ack_In = 1'b0;
    step();
    #2;
    reset = 1'b1;
    imem_Ack_In = 1'b1;
    imem_Data_In = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (imem_Req_Out !== 1'b0 || instr_Valid_Out !== 1'b0) begin
      fails++;
      $display("FAIL async_drop: req=%b v=%b want 0 0",
               imem_Req_Out, instr_Valid_Out);
    end
    repeat (2) step();
    reset = 1'b0;
    #1;
    exp_pc = 32'h0; exp_pcout = 32'h0; exp_instr = 32'h0;
    tests++;
    if (imem_Req_Out !== 1'b0 || instr_Valid_Out !== 1'b0 ||
        imem_Addr_Out !== 32'h0 || instr_Out !== 32'h0) begin
      fails++;
      $display("FAIL late_ack: req=%b v=%b addr=%h ins=%h want 0 0 0 0",
               imem_Req_Out, instr_Valid_Out, imem_Addr_Out, instr_Out);
    end
    step();
    imem_Ack_In = 1'b0;
    tests++;
    if (imem_Req_Out !== 1'b1 || imem_Addr_Out !== 32'h0 ||
        instr_Valid_Out !== 1'b0) begin
      fails++;
      $display("FAIL refetch: req=%b addr=%h v=%b want 1 0 0",
               imem_Req_Out, imem_Addr_Out, instr_Valid_Out);
    end
  endtask

  task automatic test_random;
    logic [31:0] off;
    for (int n = 0; n < 150; n++) begin
      do_fetch($urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 1) == 1) off = $urandom;
      else off = 32'($urandom_range(0, 64)) - 32'd32;
      do_issue($urandom_range(0, 3), 1'($urandom), off,
               ($urandom_range(0, 3) == 0), 26'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_redirect();
    test_stall();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
